fir_coef_ctrl: RTL and testbench

Controller and arbiter for the FIR filter's 64 x 16-bit coefficient memory (`imem`). Shares the memory's single port between a host coefficient-load interface and the per-sample tap sequencer. For each accepted input sample it sweeps addresses 0..63 and streams the coefficients to the MAC datapath with tap index and first/last markers. Sits between the host register interface, `imem`, and the FIR MAC.

---
 rtl/fir_pkg.sv | 32 +++
 rtl/fir_tap_cnt.sv | 26 ++
 rtl/fir_coef_ctrl.sv | 174 +++++++++++++++++
 tb/tb_fir_coef_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared constants, FSM state encoding and payload types for the FIR coefficient path.
// Used by fir_coef_ctrl, fir_tap_cnt, the MAC and imem.
package fir_pkg;

   localparam int unsigned NTAPS = 64;
   localparam int unsigned AW    = 6;
   localparam int unsigned DW    = 16;

   typedef enum logic [2:0] {
      FIR_IDLE     = 3'd0,
      FIR_WRITE    = 3'd1,
      FIR_READ     = 3'd2,
      FIR_READ_RSP = 3'd3,
      FIR_RUN      = 3'd4,
      FIR_DRAIN    = 3'd5
   } fir_state_e;

   // Plain constants keep the state register a bare vector for legacy tools.
   localparam logic [2:0] ST_IDLE     = 3'(FIR_IDLE);
   localparam logic [2:0] ST_WRITE    = 3'(FIR_WRITE);
   localparam logic [2:0] ST_READ     = 3'(FIR_READ);
   localparam logic [2:0] ST_READ_RSP = 3'(FIR_READ_RSP);
   localparam logic [2:0] ST_RUN      = 3'(FIR_RUN);
   localparam logic [2:0] ST_DRAIN    = 3'(FIR_DRAIN);

   typedef struct packed {
      logic          first;
      logic          last;
      logic [AW-1:0] tap;
   } coef_meta_t;

endpackage

// File: rtl/fir_tap_cnt.sv
// Tap address counter: synchronous clear, enable, saturates at NTAPS-1.
module fir_tap_cnt
   import fir_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          en,
   output logic [AW-1:0] cnt,
   output logic          tc_c
);

   assign tc_c = (cnt == AW'(NTAPS - 1));

   // Holds at the terminal count so a sweep never wraps back to tap 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && !tc_c) begin
         cnt <= cnt + AW'(1);
      end
   end

endmodule

// File: rtl/fir_coef_ctrl.sv
// Arbitrates the coefficient memory port between host load/readback and per-sample tap sweeps.
// Host readback path is built only when FIR_COEF_READBACK_EN is defined.
module fir_coef_ctrl
   import fir_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          host_valid,
   input  logic          host_we,
   input  logic [AW-1:0] host_addr,
   input  logic [DW-1:0] host_wdata,
   output logic          host_ready,
   output logic [DW-1:0] host_rdata,
   output logic          host_rvalid,
   input  logic          sample_valid,
   output logic          sample_ready,
   output logic [AW-1:0] mem_addr,
   output logic          mem_w_en,
   output logic [DW-1:0] mem_data_in,
   input  logic [DW-1:0] mem_data_out,
   output logic [DW-1:0] coef,
   output logic          coef_valid,
   output logic [AW-1:0] coef_tap,
   output logic          coef_first,
   output logic          coef_last,
   output logic          busy
);

   logic [2:0]    state;
   logic [2:0]    state_nxt;
   logic [AW-1:0] mem_addr_nxt;
   logic          mem_w_en_nxt;
   logic [DW-1:0] mem_data_in_nxt;
   logic          coef_valid_nxt;
   coef_meta_t    meta_q;
   coef_meta_t    meta_nxt;
   logic          cnt_clr;
   logic          cnt_en;
   logic [AW-1:0] cnt;
   logic          tc_c;
   logic          sample_acc_c;
   logic          host_acc_c;
`ifdef FIR_COEF_READBACK_EN
   logic          rd_cap_c;
`endif

   fir_tap_cnt u_tap_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (cnt_clr),
      .en    (cnt_en),
      .cnt   (cnt),
      .tc_c  (tc_c)
   );

   // Sample wins over the host when both request in the same IDLE cycle.
   assign sample_ready = (state == ST_IDLE);
   assign host_ready   = (state == ST_IDLE) && !sample_valid;
   assign sample_acc_c = sample_valid && sample_ready;
   assign host_acc_c   = host_valid && host_ready;

   // Synchronous-read memory already provides the one-cycle alignment with the markers.
   assign coef       = mem_data_out;
   assign coef_tap   = meta_q.tap;
   assign coef_first = meta_q.first;
   assign coef_last  = meta_q.last;

   // Next-state and next-output decode.
   always_comb begin
      state_nxt       = state;
      mem_addr_nxt    = mem_addr;
      mem_w_en_nxt    = 1'b0;
      mem_data_in_nxt = mem_data_in;
      coef_valid_nxt  = 1'b0;
      meta_nxt        = meta_q;
      meta_nxt.first  = 1'b0;
      meta_nxt.last   = 1'b0;
      cnt_clr         = 1'b0;
      cnt_en          = 1'b0;
`ifdef FIR_COEF_READBACK_EN
      rd_cap_c        = 1'b0;
`endif

      case (state)
         ST_IDLE: begin
            if (sample_acc_c) begin
               state_nxt    = ST_RUN;
               cnt_clr      = 1'b1;
               mem_addr_nxt = '0;
            end else if (host_acc_c && host_we) begin
               state_nxt       = ST_WRITE;
               mem_w_en_nxt    = 1'b1;
               mem_addr_nxt    = host_addr;
               mem_data_in_nxt = host_wdata;
`ifdef FIR_COEF_READBACK_EN
            end else if (host_acc_c) begin
               state_nxt    = ST_READ;
               mem_addr_nxt = host_addr;
`endif
            end
         end
         ST_WRITE: begin
            state_nxt = ST_IDLE;
         end
         ST_RUN: begin
            coef_valid_nxt = 1'b1;
            meta_nxt.first = (cnt == '0);
            meta_nxt.last  = tc_c;
            meta_nxt.tap   = cnt;
            if (tc_c) begin
               state_nxt = ST_DRAIN;
            end else begin
               cnt_en       = 1'b1;
               mem_addr_nxt = cnt + AW'(1);
            end
         end
         ST_DRAIN: begin
            state_nxt = ST_IDLE;
         end
`ifdef FIR_COEF_READBACK_EN
         ST_READ: begin
            state_nxt = ST_READ_RSP;
         end
         ST_READ_RSP: begin
            rd_cap_c  = 1'b1;
            state_nxt = ST_IDLE;
         end
`endif
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         mem_addr    <= '0;
         mem_w_en    <= 1'b0;
         mem_data_in <= '0;
         coef_valid  <= 1'b0;
         meta_q      <= '0;
         busy        <= 1'b0;
      end else begin
         state       <= state_nxt;
         mem_addr    <= mem_addr_nxt;
         mem_w_en    <= mem_w_en_nxt;
         mem_data_in <= mem_data_in_nxt;
         coef_valid  <= coef_valid_nxt;
         meta_q      <= meta_nxt;
         busy        <= (state_nxt != ST_IDLE);
      end
   end

`ifdef FIR_COEF_READBACK_EN
   // Capture readback one cycle after the address reached the memory.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         host_rdata  <= '0;
         host_rvalid <= 1'b0;
      end else begin
         host_rvalid <= rd_cap_c;
         if (rd_cap_c) begin
            host_rdata <= mem_data_out;
         end
      end
   end
`else
   assign host_rdata  = '0;
   assign host_rvalid = 1'b0;
`endif

endmodule

// File: tb/tb_fir_coef_ctrl.sv
// Self-checking bench for fir_coef_ctrl with a behavioural imem and a coefficient reference array.
// Honours FIR_COEF_READBACK_EN in the same way as the design.
module tb_fir_coef_ctrl;
   import fir_pkg::*;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          host_valid = 1'b0;
   logic          host_we = 1'b0;
   logic [AW-1:0] host_addr = '0;
   logic [DW-1:0] host_wdata = '0;
   logic          host_ready;
   logic [DW-1:0] host_rdata;
   logic          host_rvalid;
   logic          sample_valid = 1'b0;
   logic          sample_ready;
   logic [AW-1:0] mem_addr;
   logic          mem_w_en;
   logic [DW-1:0] mem_data_in;
   logic [DW-1:0] mem_data_out;
   logic [DW-1:0] coef;
   logic          coef_valid;
   logic [AW-1:0] coef_tap;
   logic          coef_first;
   logic          coef_last;
   logic          busy;

   logic [DW-1:0] imem    [NTAPS];
   logic [DW-1:0] ref_mem [NTAPS];

   int n_checks    = 0;
   int n_fail      = 0;
   int w_en_cycles = 0;
   int rv_cycles   = 0;
   int exp_writes  = 0;
   int exp_reads   = 0;

   always #5 clk = ~clk;

   fir_coef_ctrl dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .host_valid   (host_valid),
      .host_we      (host_we),
      .host_addr    (host_addr),
      .host_wdata   (host_wdata),
      .host_ready   (host_ready),
      .host_rdata   (host_rdata),
      .host_rvalid  (host_rvalid),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .mem_addr     (mem_addr),
      .mem_w_en     (mem_w_en),
      .mem_data_in  (mem_data_in),
      .mem_data_out (mem_data_out),
      .coef         (coef),
      .coef_valid   (coef_valid),
      .coef_tap     (coef_tap),
      .coef_first   (coef_first),
      .coef_last    (coef_last),
      .busy         (busy)
   );

   // Single-port synchronous memory, one-cycle read latency, not cleared by reset.
   always @(posedge clk) begin
      if (mem_w_en) imem[mem_addr] <= mem_data_in;
      mem_data_out <= imem[mem_addr];
   end

   always @(posedge clk) begin
      if (mem_w_en)    w_en_cycles <= w_en_cycles + 1;
      if (host_rvalid) rv_cycles   <= rv_cycles + 1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
      $fatal(1, "watchdog expired");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_vals();
      check_eq("rst.mem_addr",     32'(mem_addr),     0);
      check_eq("rst.mem_w_en",     32'(mem_w_en),     0);
      check_eq("rst.mem_data_in",  32'(mem_data_in),  0);
      check_eq("rst.coef_valid",   32'(coef_valid),   0);
      check_eq("rst.coef_tap",     32'(coef_tap),     0);
      check_eq("rst.coef_first",   32'(coef_first),   0);
      check_eq("rst.coef_last",    32'(coef_last),    0);
      check_eq("rst.host_rvalid",  32'(host_rvalid),  0);
      check_eq("rst.host_rdata",   32'(host_rdata),   0);
      check_eq("rst.busy",         32'(busy),         0);
      check_eq("rst.host_ready",   32'(host_ready),   1);
      check_eq("rst.sample_ready", 32'(sample_ready), 1);
   endtask

   task automatic host_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
      int waited = 0;
      host_valid = 1'b1;
      host_we    = 1'b1;
      host_addr  = a;
      host_wdata = d;
      #1;
      while (!host_ready && waited < 200) begin
         tick();
         waited++;
      end
      check_eq("wr.ready_timeout", 32'(waited >= 200), 0);
      tick();
      host_valid = 1'b0;
      check_eq("wr.w_en",       32'(mem_w_en),    1);
      check_eq("wr.addr",       32'(mem_addr),    32'(a));
      check_eq("wr.data",       32'(mem_data_in), 32'(d));
      check_eq("wr.ready_low",  32'(host_ready),  0);
      check_eq("wr.busy",       32'(busy),        1);
      tick();
      check_eq("wr.w_en_off",   32'(mem_w_en),    0);
      check_eq("wr.ready_back", 32'(host_ready),  1);
      ref_mem[a] = d;
      exp_writes++;
   endtask

   // Expected sweep timeline: tap k is issued in cycle k and presented to the MAC in cycle k+1.
   task automatic run_sweep(input int abort_c);
      int waited = 0;
      sample_valid = 1'b1;
      #1;
      check_eq("sw.host_blocked", 32'(host_ready), 0);
      while (!sample_ready && waited < 200) begin
         tick();
         waited++;
      end
      check_eq("sw.ready_timeout", 32'(waited >= 200), 0);
      tick();
      sample_valid = 1'b0;
      check_eq("sw.busy0",       32'(busy),         1);
      check_eq("sw.sready0",     32'(sample_ready), 0);
      check_eq("sw.addr0",       32'(mem_addr),     0);
      check_eq("sw.cvalid0",     32'(coef_valid),   0);
      for (int c = 1; c <= NTAPS + 1; c++) begin
         tick();
         check_eq("sw.coef_valid", 32'(coef_valid), 32'(c <= NTAPS));
         if (c <= NTAPS) begin
            check_eq("sw.coef_tap", 32'(coef_tap),   32'(c - 1));
            check_eq("sw.coef",     32'(coef),       32'(ref_mem[AW'(c - 1)]));
            check_eq("sw.first",    32'(coef_first), 32'(c == 1));
            check_eq("sw.last",     32'(coef_last),  32'(c == NTAPS));
         end else begin
            check_eq("sw.first_idle", 32'(coef_first), 0);
            check_eq("sw.last_idle",  32'(coef_last),  0);
         end
         if (c < NTAPS) check_eq("sw.mem_addr", 32'(mem_addr), 32'(c));
         check_eq("sw.no_write",     32'(mem_w_en),     0);
         check_eq("sw.sample_ready", 32'(sample_ready), 32'(c == NTAPS + 1));
         check_eq("sw.host_ready",   32'(host_ready),   32'(c == NTAPS + 1));
         check_eq("sw.busy",         32'(busy),         32'(c <= NTAPS));
         if (c == abort_c) begin
            rst_n = 1'b0;
            #1;
            check_reset_vals();
            tick();
            check_reset_vals();
            rst_n = 1'b1;
            return;
         end
      end
   endtask

   task automatic host_read(input logic [AW-1:0] a);
      int waited = 0;
      host_valid = 1'b1;
      host_we    = 1'b0;
      host_addr  = a;
      #1;
      while (!host_ready && waited < 200) begin
         tick();
         waited++;
      end
      check_eq("rd.ready_timeout", 32'(waited >= 200), 0);
      tick();
      host_valid = 1'b0;
`ifdef FIR_COEF_READBACK_EN
      check_eq("rd.busy",      32'(busy),        1);
      check_eq("rd.rvalid_e0", 32'(host_rvalid), 0);
      tick();
      check_eq("rd.rvalid_e1", 32'(host_rvalid), 0);
      tick();
      check_eq("rd.rvalid_e2", 32'(host_rvalid), 1);
      check_eq("rd.rdata",     32'(host_rdata),  32'(ref_mem[a]));
      tick();
      check_eq("rd.rvalid_e3", 32'(host_rvalid), 0);
      check_eq("rd.ready_e3",  32'(host_ready),  1);
      check_eq("rd.idle_e3",   32'(busy),        0);
      exp_reads++;
`else
      check_eq("rd.discard_busy",  32'(busy),        0);
      check_eq("rd.discard_ready", 32'(host_ready),  1);
      check_eq("rd.no_wen",        32'(mem_w_en),    0);
      tick();
      tick();
      check_eq("rd.no_rvalid",     32'(host_rvalid), 0);
      check_eq("rd.rdata_zero",    32'(host_rdata),  0);
`endif
   endtask

   initial begin
      logic [AW-1:0] ra;
      logic [DW-1:0] rd;
      for (int i = 0; i < NTAPS; i++) ref_mem[i] = '0;

      #2;
      check_reset_vals();
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      check_reset_vals();

      for (int i = 0; i < NTAPS; i++) host_write(AW'(i), DW'(16'h1000 + i));
      run_sweep(-1);

      // Sweep and write requested together: sweep first, write held until IDLE.
      host_valid = 1'b1;
      host_we    = 1'b1;
      host_addr  = AW'(5);
      host_wdata = DW'(16'hBEEF);
      run_sweep(-1);
      host_write(AW'(5), DW'(16'hBEEF));
      run_sweep(-1);

      host_read(AW'(6'h2A));

      run_sweep(30);
      run_sweep(-1);

      for (int it = 0; it < 24; it++) begin
         ra = AW'($urandom_range(0, NTAPS - 1));
         rd = DW'($urandom);
         case ($urandom_range(0, 3))
            0: host_write(ra, rd);
            1: run_sweep(-1);
            2: host_read(ra);
            default: begin
               host_valid = 1'b1;
               host_we    = 1'b1;
               host_addr  = ra;
               host_wdata = rd;
               run_sweep(-1);
               host_write(ra, rd);
            end
         endcase
         repeat ($urandom_range(0, 2)) tick();
      end
      run_sweep(-1);
      tick();

      check_eq("mon.w_en_cycles",   32'(w_en_cycles), 32'(exp_writes));
      check_eq("mon.rvalid_pulses", 32'(rv_cycles),   32'(exp_reads));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
